// File: rtl/ad_ip_jesd204_tpl_adc_pn_stat.sv
// ---------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_pn_stat
//
// Per-channel PN health stage behind the TPL ADC PN monitor. It turns the raw
// per-cycle pn_oos/pn_err flags into a debounced lock state, error and
// lock-loss counters, an acquisition-time measurement and sticky flags. It
// also offers a 4-phase clear handshake toward the register map.
//
// Ports:
//   clk            ADC link clock (the PN monitor runs on this clock too)
//   resetn         synchronous active-low reset
//   enable         statistics enable (already in the clk domain)
//   pn_oos         PN out-of-sync flag from the monitor
//   pn_err         PN per-cycle error flag from the monitor
//   pn_seq_sel     PN sequence select (same value that drives the monitor)
//   clr_req        clear request, level, 4-phase
//   clr_ack        clear acknowledge
//   pn_state       0 DISABLED, 1 SEARCH, 2 SETTLE, 3 LOCKED
//   pn_locked      high while pn_state is LOCKED
//   pn_err_sticky  set by any pn_err seen while LOCKED
//   pn_loss_sticky set by any LOCKED->SEARCH transition
//   err_cnt        saturating count of errors seen while LOCKED
//   loss_cnt       saturating count of lock losses
//   lock_time      cycles from the last SEARCH entry to LOCKED entry
// ---------------------------------------------------------------------------
module ad_ip_jesd204_tpl_adc_pn_stat #(
  parameter int unsigned ERR_CNT_WIDTH   = 32,
  parameter int unsigned LOSS_CNT_WIDTH  = 16,
  parameter int unsigned LOCK_TIME_WIDTH = 24,
  parameter int unsigned LOCK_THRESHOLD  = 64
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic                       pn_oos,
  input  logic                       pn_err,
  input  logic [3:0]                 pn_seq_sel,
  input  logic                       clr_req,
  output logic                       clr_ack,
  output logic [1:0]                 pn_state,
  output logic                       pn_locked,
  output logic                       pn_err_sticky,
  output logic                       pn_loss_sticky,
  output logic [ERR_CNT_WIDTH-1:0]   err_cnt,
  output logic [LOSS_CNT_WIDTH-1:0]  loss_cnt,
  output logic [LOCK_TIME_WIDTH-1:0] lock_time
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SEARCH   = 2'd1,
    ST_SETTLE   = 2'd2,
    ST_LOCKED   = 2'd3
  } state_t;

  localparam logic [15:0] LP_THRESH = 16'(LOCK_THRESHOLD);

  state_t                     r_state;
  logic [15:0]                r_settle_cnt;
  logic [LOCK_TIME_WIDTH-1:0] r_timer;
  logic [3:0]                 r_seq_sel;
  logic                       r_clr_ack;
  logic                       r_err_sticky;
  logic                       r_loss_sticky;
  logic [ERR_CNT_WIDTH-1:0]   r_err_cnt;
  logic [LOSS_CNT_WIDTH-1:0]  r_loss_cnt;
  logic [LOCK_TIME_WIDTH-1:0] r_lock_time;

  state_t                     w_state_nxt;
  logic [15:0]                w_settle_nxt;
  logic [LOCK_TIME_WIDTH-1:0] w_timer_nxt;
  logic [LOCK_TIME_WIDTH-1:0] w_timer_inc;
  logic                       w_seq_chg;
  logic                       w_clr_hs;
  logic                       w_clear;
  logic                       w_lock_evt;
  logic                       w_loss_evt;
  logic                       w_err_evt;

  // A sequence change only matters once statistics are running; while
  // DISABLED the copy simply tracks the input.
  assign w_seq_chg = enable && (r_state != ST_DISABLED) && (pn_seq_sel != r_seq_sel);
  // One clear per handshake: it fires only while the ack is still low.
  assign w_clr_hs  = clr_req && !r_clr_ack;
  assign w_clear   = w_clr_hs || w_seq_chg;
  assign w_err_evt = enable && (r_state == ST_LOCKED) && pn_err;

  assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + LOCK_TIME_WIDTH'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    w_timer_nxt  = r_timer;
    w_lock_evt   = 1'b0;
    w_loss_evt   = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_DISABLED;
    end else if (r_state == ST_DISABLED) begin
      w_state_nxt  = ST_SEARCH;
      w_timer_nxt  = '0;
      w_settle_nxt = '0;
    end else if (w_seq_chg) begin
      w_state_nxt  = ST_SEARCH;
      w_timer_nxt  = '0;
      w_settle_nxt = '0;
    end else begin
      case (r_state)
        ST_SEARCH: begin
          w_timer_nxt = w_timer_inc;
          if (!pn_oos && !pn_err) begin
            if (LOCK_THRESHOLD == 1) begin
              w_state_nxt = ST_LOCKED;
              w_lock_evt  = 1'b1;
            end else begin
              w_state_nxt  = ST_SETTLE;
              w_settle_nxt = 16'd1;
            end
          end
        end
        ST_SETTLE: begin
          w_timer_nxt = w_timer_inc;
          if (pn_oos) begin
            w_state_nxt  = ST_SEARCH;
            w_settle_nxt = '0;
          end else if (pn_err) begin
            w_settle_nxt = '0;
          end else if (r_settle_cnt >= LP_THRESH) begin
            // Lock is declared on the clean edge after the count has
            // reached the threshold.
            w_state_nxt = ST_LOCKED;
            w_lock_evt  = 1'b1;
          end else begin
            w_settle_nxt = r_settle_cnt + 16'd1;
          end
        end
        ST_LOCKED: begin
          if (pn_oos) begin
            w_state_nxt  = ST_SEARCH;
            w_timer_nxt  = '0;
            w_settle_nxt = '0;
            w_loss_evt   = 1'b1;
          end
        end
        default: w_state_nxt = ST_DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= ST_DISABLED;
      r_settle_cnt  <= '0;
      r_timer       <= '0;
      r_seq_sel     <= '0;
      r_clr_ack     <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_loss_sticky <= 1'b0;
      r_err_cnt     <= '0;
      r_loss_cnt    <= '0;
      r_lock_time   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_timer      <= w_timer_nxt;
      r_seq_sel    <= pn_seq_sel;
      r_clr_ack    <= clr_req;
      // Clear wins over any count/sticky/capture event on the same edge.
      if (w_clear) begin
        r_err_sticky  <= 1'b0;
        r_loss_sticky <= 1'b0;
        r_err_cnt     <= '0;
        r_loss_cnt    <= '0;
        r_lock_time   <= '0;
      end else begin
        if (w_err_evt) begin
          r_err_sticky <= 1'b1;
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
        end
        if (w_loss_evt) begin
          r_loss_sticky <= 1'b1;
          if (r_loss_cnt != '1) r_loss_cnt <= r_loss_cnt + LOSS_CNT_WIDTH'(1);
        end
        if (w_lock_evt) r_lock_time <= w_timer_inc;
      end
    end
  end

  assign clr_ack        = r_clr_ack;
  assign pn_state       = r_state;
  assign pn_locked      = (r_state == ST_LOCKED);
  assign pn_err_sticky  = r_err_sticky;
  assign pn_loss_sticky = r_loss_sticky;
  assign err_cnt        = r_err_cnt;
  assign loss_cnt       = r_loss_cnt;
  assign lock_time      = r_lock_time;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_stat.sv
// ---------------------------------------------------------------------------
// tb_ad_ip_jesd204_tpl_adc_pn_stat
//
// Directed bench for ad_ip_jesd204_tpl_adc_pn_stat with a 4-bit error
// counter and a lock threshold of 64. Inputs change 1 ns after a rising
// edge and outputs are checked 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_ad_ip_jesd204_tpl_adc_pn_stat;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        pn_oos;
  logic        pn_err;
  logic [3:0]  pn_seq_sel;
  logic        clr_req;
  logic        clr_ack;
  logic [1:0]  pn_state;
  logic        pn_locked;
  logic        pn_err_sticky;
  logic        pn_loss_sticky;
  logic [3:0]  err_cnt;
  logic [15:0] loss_cnt;
  logic [23:0] lock_time;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_adc_pn_stat #(
    .ERR_CNT_WIDTH  (4),
    .LOSS_CNT_WIDTH (16),
    .LOCK_TIME_WIDTH(24),
    .LOCK_THRESHOLD (64)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .pn_oos        (pn_oos),
    .pn_err        (pn_err),
    .pn_seq_sel    (pn_seq_sel),
    .clr_req       (clr_req),
    .clr_ack       (clr_ack),
    .pn_state      (pn_state),
    .pn_locked     (pn_locked),
    .pn_err_sticky (pn_err_sticky),
    .pn_loss_sticky(pn_loss_sticky),
    .err_cnt       (err_cnt),
    .loss_cnt      (loss_cnt),
    .lock_time     (lock_time)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; pn_oos = 1'b0; pn_err = 1'b0;
    pn_seq_sel = 4'd0; clr_req = 1'b0;
    tick(2);
    chk("rst_state",     32'(pn_state), 32'd0);
    chk("rst_locked",    32'(pn_locked), 32'd0);
    chk("rst_err_cnt",   32'(err_cnt), 32'd0);
    chk("rst_loss_cnt",  32'(loss_cnt), 32'd0);
    chk("rst_lock_time", 32'(lock_time), 32'd0);
    chk("rst_clr_ack",   32'(clr_ack), 32'd0);
    chk("rst_stickies",  32'({pn_err_sticky, pn_loss_sticky}), 32'd0);

    resetn = 1'b1;
    tick(1);
    chk("idle_disabled", 32'(pn_state), 32'd0);

    // Acquisition: enable sampled at E0, lock at E65.
    enable = 1'b1;
    tick(1);
    chk("acq_search", 32'(pn_state), 32'd1);
    tick(1);
    chk("acq_settle", 32'(pn_state), 32'd2);
    tick(63);
    chk("acq_not_yet", 32'(pn_locked), 32'd0);
    tick(1);
    chk("acq_locked",    32'(pn_locked), 32'd1);
    chk("acq_state",     32'(pn_state), 32'd3);
    chk("acq_lock_time", 32'(lock_time), 32'd65);
    chk("acq_err_cnt",   32'(err_cnt), 32'd0);

    // Three isolated errors, then a lock loss.
    for (int i = 0; i < 3; i++) begin
      pn_err = 1'b1; tick(1);
      pn_err = 1'b0; tick(1);
    end
    chk("err3_cnt",    32'(err_cnt), 32'd3);
    chk("err3_sticky", 32'(pn_err_sticky), 32'd1);
    pn_oos = 1'b1; tick(1);
    pn_oos = 1'b0;
    chk("loss_cnt",    32'(loss_cnt), 32'd1);
    chk("loss_sticky", 32'(pn_loss_sticky), 32'd1);
    chk("loss_state",  32'(pn_state), 32'd1);
    chk("loss_errcnt", 32'(err_cnt), 32'd3);

    // Settle count reaches 40, then one error restarts it.
    tick(40);
    chk("settle40_state", 32'(pn_state), 32'd2);
    pn_err = 1'b1; tick(1);
    pn_err = 1'b0;
    chk("settle_err_state", 32'(pn_state), 32'd2);
    tick(24);
    chk("settle_no_early", 32'(pn_locked), 32'd0);
    tick(40);
    chk("settle_64_not", 32'(pn_locked), 32'd0);
    tick(1);
    chk("relock",      32'(pn_locked), 32'd1);
    chk("relock_time", 32'(lock_time), 32'd106);

    // Saturate the 4-bit error counter from 3.
    pn_err = 1'b1;
    tick(12);
    chk("sat_reach", 32'(err_cnt), 32'd15);
    tick(8);
    chk("sat_hold", 32'(err_cnt), 32'd15);

    // Clear with a coincident error: the error is discarded.
    clr_req = 1'b1;
    tick(1);
    chk("clr_err_cnt",   32'(err_cnt), 32'd0);
    chk("clr_ack_hi",    32'(clr_ack), 32'd1);
    chk("clr_stickies",  32'({pn_err_sticky, pn_loss_sticky}), 32'd0);
    chk("clr_loss_cnt",  32'(loss_cnt), 32'd0);
    chk("clr_lock_time", 32'(lock_time), 32'd0);
    chk("clr_state",     32'(pn_state), 32'd3);
    tick(4);
    chk("clr_hold_cnt", 32'(err_cnt), 32'd4);
    chk("clr_hold_ack", 32'(clr_ack), 32'd1);
    clr_req = 1'b0; pn_err = 1'b0;
    tick(1);
    chk("clr_ack_lo",   32'(clr_ack), 32'd0);
    chk("clr_end_cnt",  32'(err_cnt), 32'd4);

    // Sequence change while locked at err_cnt=7, with pn_oos on the same edge.
    pn_err = 1'b1; tick(3); pn_err = 1'b0;
    chk("pre_seq_cnt", 32'(err_cnt), 32'd7);
    pn_seq_sel = 4'd1; pn_oos = 1'b1;
    tick(1);
    pn_oos = 1'b0;
    chk("seq_state",    32'(pn_state), 32'd1);
    chk("seq_err_cnt",  32'(err_cnt), 32'd0);
    chk("seq_loss_cnt", 32'(loss_cnt), 32'd0);
    chk("seq_stickies", 32'({pn_err_sticky, pn_loss_sticky}), 32'd0);
    chk("seq_clr_ack",  32'(clr_ack), 32'd0);

    tick(65);
    chk("seq_relock",      32'(pn_locked), 32'd1);
    chk("seq_relock_time", 32'(lock_time), 32'd65);

    // Disable while locked: state drops, counters hold.
    pn_err = 1'b1; tick(2); pn_err = 1'b0;
    enable = 1'b0;
    tick(1);
    chk("dis_state",     32'(pn_state), 32'd0);
    chk("dis_err_cnt",   32'(err_cnt), 32'd2);
    chk("dis_lock_time", 32'(lock_time), 32'd65);
    pn_err = 1'b1; tick(3); pn_err = 1'b0;
    chk("dis_no_count", 32'(err_cnt), 32'd2);
    enable = 1'b1;
    tick(1);
    chk("reen_state", 32'(pn_state), 32'd1);
    tick(10);
    chk("reen_lock_time", 32'(lock_time), 32'd65);
    tick(55);
    chk("reen_locked", 32'(pn_locked), 32'd1);

    // Reset during a clear handshake while locked.
    clr_req = 1'b1; pn_err = 1'b1;
    tick(1);
    tick(1);
    chk("pre_rst_cnt", 32'(err_cnt), 32'd1);
    chk("pre_rst_ack", 32'(clr_ack), 32'd1);
    resetn = 1'b0;
    tick(1);
    chk("mid_rst_ack",    32'(clr_ack), 32'd0);
    chk("mid_rst_state",  32'(pn_state), 32'd0);
    chk("mid_rst_cnt",    32'(err_cnt), 32'd0);
    chk("mid_rst_sticky", 32'(pn_err_sticky), 32'd0);
    chk("mid_rst_locked", 32'(pn_locked), 32'd0);

    clr_req = 1'b0; pn_err = 1'b0; enable = 1'b0; resetn = 1'b1;
    tick(2);
    chk("post_rst_state", 32'(pn_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
